// File: rtl/mem_rw_arbiter.sv
// Arbitrates the shared cache-to-memory port between icache reads and dcache reads/writes.
// Round-robin read grant held to the last return beat, one-entry write buffer, RAW line stall.
module mem_rw_arbiter #(
  parameter int LINE_OFS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         m_rd_req,
  output logic [2:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic         m_ret_last,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    D_REQ  = 3'd2,
    I_WAIT = 3'd3,
    D_WAIT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: most recent grant went to dcache
  logic [2:0]    rd_type_q, rd_type_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic          wbuf_valid_q, wbuf_valid_d;
  logic [2:0]    wbuf_type_q;
  logic [31:0]   wbuf_addr_q;
  logic [3:0]    wbuf_wstrb_q;
  logic [127:0]  wbuf_data_q;
  logic          i_elig_s, d_elig_s, wr_take_s, wr_done_s;

  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINE_OFS] == b[31:LINE_OFS];
  endfunction

  // A read to the line held in the write buffer must wait until the write drains.
  always_comb begin
    i_elig_s = i_rd_req && !(wbuf_valid_q && same_line(i_rd_addr, wbuf_addr_q));
    d_elig_s = d_rd_req && !(wbuf_valid_q && same_line(d_rd_addr, wbuf_addr_q));
  end

  // Read FSM: next state, latched request and steered handshakes.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    rd_type_d   = rd_type_q;
    rd_addr_d   = rd_addr_q;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    m_rd_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_elig_s && (!d_elig_s || last_d_q)) begin
          state_d   = I_REQ;
          last_d_d  = 1'b0;
          rd_type_d = i_rd_type;
          rd_addr_d = i_rd_addr;
        end else if (d_elig_s) begin
          state_d   = D_REQ;
          last_d_d  = 1'b1;
          rd_type_d = d_rd_type;
          rd_addr_d = d_rd_addr;
        end else begin
          state_d = IDLE;
        end
      end
      I_REQ: begin
        m_rd_req = 1'b1;
        i_rd_rdy = m_rd_rdy;
        state_d  = m_rd_rdy ? I_WAIT : I_REQ;
      end
      D_REQ: begin
        m_rd_req = 1'b1;
        d_rd_rdy = m_rd_rdy;
        state_d  = m_rd_rdy ? D_WAIT : D_REQ;
      end
      I_WAIT: begin
        i_ret_valid = m_ret_valid;
        state_d     = (m_ret_valid && m_ret_last) ? IDLE : I_WAIT;
      end
      D_WAIT: begin
        d_ret_valid = m_ret_valid;
        state_d     = (m_ret_valid && m_ret_last) ? IDLE : D_WAIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read FSM state and latched request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      rd_type_q <= 3'b000;
      rd_addr_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      rd_type_q <= rd_type_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign m_rd_type = rd_type_q;
  assign m_rd_addr = rd_addr_q;

  // Buffer occupancy: fill only when empty, so a drain and a refill never share a cycle.
  always_comb begin
    wr_take_s = d_wr_req && !wbuf_valid_q;
    wr_done_s = wbuf_valid_q && m_wr_rdy;
    if (wr_done_s) begin
      wbuf_valid_d = 1'b0;
    end else if (wr_take_s) begin
      wbuf_valid_d = 1'b1;
    end else begin
      wbuf_valid_d = wbuf_valid_q;
    end
  end

  // Write buffer storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wbuf_valid_q <= 1'b0;
      wbuf_type_q  <= 3'b000;
      wbuf_addr_q  <= 32'h0000_0000;
      wbuf_wstrb_q <= 4'h0;
      wbuf_data_q  <= 128'h0;
    end else begin
      wbuf_valid_q <= wbuf_valid_d;
      if (wr_take_s) begin
        wbuf_type_q  <= d_wr_type;
        wbuf_addr_q  <= d_wr_addr;
        wbuf_wstrb_q <= d_wr_wstrb;
        wbuf_data_q  <= d_wr_data;
      end
    end
  end

  // Held low during reset so every output reads 0 while resetn is asserted.
  assign d_wr_rdy   = resetn && !wbuf_valid_q;
  assign m_wr_req   = wbuf_valid_q;
  assign m_wr_type  = wbuf_type_q;
  assign m_wr_addr  = wbuf_addr_q;
  assign m_wr_wstrb = wbuf_wstrb_q;
  assign m_wr_data  = wbuf_data_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter: table of single reads, scoreboards for
// read grants and buffered writes, plus hand-written arbitration/hazard/reset sequences.
module tb_mem_rw_arbiter;

  logic         clk, resetn;
  logic         i_rd_req;  logic [2:0] i_rd_type;  logic [31:0] i_rd_addr;
  logic         i_rd_rdy, i_ret_valid;
  logic         d_rd_req;  logic [2:0] d_rd_type;  logic [31:0] d_rd_addr;
  logic         d_rd_rdy, d_ret_valid;
  logic         d_wr_req;  logic [2:0] d_wr_type;  logic [31:0] d_wr_addr;
  logic [3:0]   d_wr_wstrb; logic [127:0] d_wr_data; logic d_wr_rdy;
  logic         m_rd_req;  logic [2:0] m_rd_type;  logic [31:0] m_rd_addr;
  logic         m_rd_rdy, m_ret_valid, m_ret_last;
  logic         m_wr_req;  logic [2:0] m_wr_type;  logic [31:0] m_wr_addr;
  logic [3:0]   m_wr_wstrb; logic [127:0] m_wr_data; logic m_wr_rdy;

  int n_cmp;
  int n_bad;

  typedef struct { logic is_d; logic [2:0] typ; logic [31:0] addr; } rd_exp_t;
  typedef struct { logic [2:0] typ; logic [31:0] addr; logic [3:0] wstrb; logic [127:0] data; } wr_exp_t;
  typedef struct { logic is_d; logic [31:0] addr; logic [2:0] typ; int rdy_dly; int beats; int exp_lat; } rd_vec_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  logic    wfull_m;
  rd_vec_t vecs[4];

  mem_rw_arbiter #(.LINE_OFS(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
    .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic is_d, input logic [31:0] addr, input logic [2:0] typ);
    rd_exp_t e;
    e.is_d = is_d; e.addr = addr; e.typ = typ;
    rq.push_back(e);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rd_outs", 256'({i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, d_wr_rdy,
                              m_rd_req, m_rd_type, m_rd_addr, m_wr_req, m_wr_type,
                              m_wr_addr, m_wr_wstrb}), 256'(0));
    chk("rst_wr_data", 256'(m_wr_data), 256'(0));
  endtask

  // Called at a negedge; returns at a negedge with the FSM back in IDLE.
  task automatic do_read(input logic is_d, input logic [31:0] addr, input logic [2:0] typ,
                         input int rdy_dly, input int beats, input int exp_lat);
    int lat; int own; int oth; rd_exp_t e; logic [1:0] exp_rdy;
    if (is_d) begin d_rd_req = 1'b1; d_rd_addr = addr; d_rd_type = typ; end
    else begin i_rd_req = 1'b1; i_rd_addr = addr; i_rd_type = typ; end
    lat = 0;
    while (!m_rd_req && lat < 20) begin @(negedge clk); lat++; end
    chk("grant_lat", 256'(lat), 256'(exp_lat));
    for (int k = 0; k < rdy_dly; k++) begin
      cyc(); m_ret_valid = 1'b1; m_ret_last = 1'b1;
      @(negedge clk);
      chk("req_stray_ret", 256'({i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy}), 256'(0));
    end
    cyc(); m_ret_valid = 1'b0; m_ret_last = 1'b0; m_rd_rdy = 1'b1;
    @(negedge clk);
    chk("rd_sb_depth", 256'(rq.size() > 0), 256'(1));
    if (rq.size() > 0) e = rq.pop_front();
    else begin e.is_d = is_d; e.addr = addr; e.typ = typ; end
    exp_rdy = e.is_d ? 2'b10 : 2'b01;
    chk("rd_rdy", 256'({d_rd_rdy, i_rd_rdy}), 256'(exp_rdy));
    chk("rd_addr", 256'(m_rd_addr), 256'(e.addr));
    chk("rd_type", 256'(m_rd_type), 256'(e.typ));
    own = 0; oth = 0;
    for (int b = 0; b < beats; b++) begin
      cyc();
      m_rd_rdy = 1'b0;
      if (is_d) d_rd_req = 1'b0; else i_rd_req = 1'b0;
      m_ret_valid = 1'b1; m_ret_last = (b == beats - 1);
      @(negedge clk);
      if (e.is_d ? d_ret_valid : i_ret_valid) own++;
      if (e.is_d ? i_ret_valid : d_ret_valid) oth++;
    end
    cyc(); m_ret_valid = 1'b0; m_ret_last = 1'b0;
    @(negedge clk);
    chk("ret_own_beats", 256'(own), 256'(beats));
    chk("ret_other_beats", 256'(oth), 256'(0));
    chk("idle_after_last", 256'({m_rd_req, i_ret_valid, d_ret_valid}), 256'(0));
  endtask

  // One write-path cycle checked against the bench's own buffer model.
  task automatic wr_step(input logic req, input logic rdy, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [127:0] data, output logic acc);
    wr_exp_t e;
    cyc();
    d_wr_req = req; d_wr_type = 3'b100; d_wr_addr = addr;
    d_wr_wstrb = wstrb; d_wr_data = data; m_wr_rdy = rdy;
    @(negedge clk);
    chk("d_wr_rdy", 256'(d_wr_rdy), 256'(!wfull_m));
    chk("m_wr_req", 256'(m_wr_req), 256'(wfull_m));
    acc = req && !wfull_m;
    if (wfull_m && rdy) begin
      chk("wr_sb_depth", 256'(wq.size() > 0), 256'(1));
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", 256'(m_wr_addr), 256'(e.addr));
        chk("wr_data", 256'(m_wr_data), 256'(e.data));
        chk("wr_strb_type", 256'({m_wr_wstrb, m_wr_type}), 256'({e.wstrb, e.typ}));
      end
    end
    if (acc) begin
      e.typ = 3'b100; e.addr = addr; e.wstrb = wstrb; e.data = data;
      wq.push_back(e);
    end
    wfull_m = wfull_m ? !rdy : req;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    int idx;
    logic [31:0] wa;
    n_cmp = 0; n_bad = 0; wfull_m = 1'b0;
    resetn = 1'b0;
    i_rd_req = 1'b0; i_rd_type = 3'b000; i_rd_addr = 32'h0;
    d_rd_req = 1'b0; d_rd_type = 3'b000; d_rd_addr = 32'h0;
    d_wr_req = 1'b0; d_wr_type = 3'b000; d_wr_addr = 32'h0; d_wr_wstrb = 4'h0; d_wr_data = 128'h0;
    m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_wr_rdy = 1'b0;

    vecs[0] = '{1'b0, 32'h1c00_0000, 3'b100, 2, 4, 1};
    vecs[1] = '{1'b1, 32'h0000_0040, 3'b010, 0, 1, 1};
    vecs[2] = '{1'b1, 32'h8000_1230, 3'b100, 1, 4, 1};
    vecs[3] = '{1'b0, 32'hbfc0_0000, 3'b100, 0, 2, 1};

    @(negedge clk);
    chk_reset_outs();
    cyc(); resetn = 1'b1;
    @(negedge clk);
    chk("wr_rdy_after_reset", 256'(d_wr_rdy), 256'(1));

    // Both caches request together: icache first out of reset, then strict alternation.
    for (int r = 0; r < 2; r++) begin
      d_rd_req = 1'b1; d_rd_addr = 32'h0000_0100 + 32'(r) * 32'h40; d_rd_type = 3'b100;
      push_rd(1'b0, 32'h1c00_0040 + 32'(r) * 32'h40, 3'b100);
      push_rd(1'b1, 32'h0000_0100 + 32'(r) * 32'h40, 3'b100);
      do_read(1'b0, 32'h1c00_0040 + 32'(r) * 32'h40, 3'b100, 0, 4, 1);
      do_read(1'b1, 32'h0000_0100 + 32'(r) * 32'h40, 3'b100, 1, 2, 1);
    end

    for (int v = 0; v < 4; v++) begin
      push_rd(vecs[v].is_d, vecs[v].addr, vecs[v].typ);
      do_read(vecs[v].is_d, vecs[v].addr, vecs[v].typ, vecs[v].rdy_dly, vecs[v].beats, vecs[v].exp_lat);
    end

    for (int k = 0; k < 2; k++) begin
      cyc(); m_ret_valid = 1'b1; m_ret_last = 1'b1;
      @(negedge clk);
      chk("idle_stray_ret", 256'({i_ret_valid, d_ret_valid, m_rd_req}), 256'(0));
    end
    cyc(); m_ret_valid = 1'b0; m_ret_last = 1'b0;
    @(negedge clk);

    // Read-after-write to the same 16-byte line stalls until the buffer drains.
    wr_step(1'b1, 1'b0, 32'h0000_1008, 4'h3, {4{32'hdead_1008}}, acc);
    wr_step(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, acc);
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_1000; d_rd_type = 3'b100;
    push_rd(1'b1, 32'h0000_1000, 3'b100);
    for (int k = 0; k < 3; k++) begin
      wr_step(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, acc);
      chk("raw_hold", 256'(m_rd_req), 256'(0));
    end
    wr_step(1'b0, 1'b1, 32'h0, 4'h0, 128'h0, acc);
    chk("raw_hold_drain", 256'(m_rd_req), 256'(0));
    do_read(1'b1, 32'h0000_1000, 3'b100, 0, 4, 2);

    // A different line proceeds while the write is still pending.
    wr_step(1'b1, 1'b0, 32'h0000_2000, 4'hf, {4{32'h2000_cafe}}, acc);
    wr_step(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, acc);
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_3000; d_rd_type = 3'b100;
    push_rd(1'b1, 32'h0000_3000, 3'b100);
    cyc();
    @(negedge clk);
    chk("rd_wr_concurrent", 256'({m_rd_req, m_wr_req}), 256'(2'b11));
    do_read(1'b1, 32'h0000_3000, 3'b100, 0, 2, 0);
    wr_step(1'b0, 1'b1, 32'h0, 4'h0, 128'h0, acc);

    // Three back-to-back writes against alternating memory readiness.
    idx = 0;
    for (int s = 0; s < 12; s++) begin
      wa = 32'h0000_4000 + 32'(idx) * 32'h10;
      wr_step(idx < 3, (s % 2) == 1, wa, 4'hf ^ 4'(idx), {4{wa ^ 32'ha5a5_0000}}, acc);
      if (acc) idx++;
    end
    chk("wr_all_accepted", 256'(idx), 256'(3));
    chk("wr_all_drained", 256'(wq.size()), 256'(0));

    // Reset asserted in the middle of an icache return burst.
    i_rd_req = 1'b1; i_rd_addr = 32'h1c00_0100; i_rd_type = 3'b100;
    cyc(); m_rd_rdy = 1'b1;
    cyc(); m_rd_rdy = 1'b0; i_rd_req = 1'b0; m_ret_valid = 1'b1; m_ret_last = 1'b0;
    cyc();
    @(negedge clk);
    chk("pre_reset_beat", 256'(i_ret_valid), 256'(1));
    #1 resetn = 1'b0;
    #1 chk_reset_outs();
    m_ret_valid = 1'b0;
    cyc(); cyc(); resetn = 1'b1;
    @(negedge clk);
    push_rd(1'b1, 32'h0000_5000, 3'b100);
    do_read(1'b1, 32'h0000_5000, 3'b100, 1, 2, 1);
    chk("rd_sb_drained", 256'(rq.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
